// File: rtl/lib_voq_input_buffer.sv
// Per-input virtual output queue buffer: M circular FIFOs feeding an allocator
// request row and dequeuing the flit selected by that input's grant column.
module lib_voq_input_buffer #(
  parameter int unsigned M     = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic [WIDTH-1:0]     i_data,
  input  logic [$clog2(M)-1:0] i_dest,
  input  logic                 i_valid,
  output logic [0:M-1]         o_full,
  output logic                 o_overflow,
  output logic [0:M-1]         o_request,
  input  logic [0:M-1]         i_grant,
  output logic [WIDTH-1:0]     o_data,
  output logic                 o_valid,
  output logic [0:M-1]         o_dest,
  output logic                 o_error
);

  localparam int unsigned DW = $clog2(M);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem    [M][DEPTH];
  logic [PW-1:0]    wr_ptr [M];
  logic [PW-1:0]    rd_ptr [M];
  logic [CW-1:0]    count  [M];

  logic [DW-1:0] sel;
  logic          found;
  logic          multi;
  logic          dest_ok;
  logic          push_ok;
  logic          push_rej;
  logic          pop_ok;
  logic          err_ev;
  logic [0:M-1]  sel_onehot;

  // Status flags depend only on the occupancy counters.
  always_comb begin
    o_full    = '0;
    o_request = '0;
    for (int unsigned j = 0; j < M; j++) begin
      o_full[j]    = (count[j] == CW'(DEPTH));
      o_request[j] = (count[j] != '0);
    end
  end

  // Lowest-index grant wins; extra grant bits are a protocol error.
  always_comb begin
    sel        = '0;
    found      = 1'b0;
    sel_onehot = '0;
    for (int unsigned j = 0; j < M; j++) begin
      if (i_grant[j] && !found) begin
        sel   = DW'(j);
        found = 1'b1;
      end
    end
    sel_onehot[sel] = found;
    multi    = ($countones(i_grant) > 1);
    dest_ok  = (32'(i_dest) < 32'(M));
    push_ok  = ce && i_valid && dest_ok && !o_full[i_dest];
    push_rej = ce && i_valid && dest_ok && o_full[i_dest];
    pop_ok   = ce && found && (count[sel] != '0);
    err_ev   = ce && found && ((count[sel] == '0) || multi);
  end

  // Flit storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[i_dest][wr_ptr[i_dest]] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned j = 0; j < M; j++) begin
        wr_ptr[j] <= '0;
        rd_ptr[j] <= '0;
        count[j]  <= '0;
      end
      o_valid    <= 1'b0;
      o_overflow <= 1'b0;
      o_error    <= 1'b0;
      o_data     <= '0;
      o_dest     <= '0;
    end else begin
      o_valid    <= pop_ok;
      o_overflow <= push_rej;
      o_error    <= err_ev;
      if (pop_ok) begin
        o_data <= mem[sel][rd_ptr[sel]];
        o_dest <= sel_onehot;
      end
      for (int unsigned j = 0; j < M; j++) begin
        if (push_ok && (i_dest == DW'(j))) begin
          wr_ptr[j] <= wr_ptr[j] + PW'(1);
        end
        if (pop_ok && (sel == DW'(j))) begin
          rd_ptr[j] <= rd_ptr[j] + PW'(1);
        end
        count[j] <= count[j] + CW'(push_ok && (i_dest == DW'(j)))
                             - CW'(pop_ok && (sel == DW'(j)));
      end
    end
  end

endmodule

// File: tb/tb_lib_voq_input_buffer.sv
// Directed bench for lib_voq_input_buffer: queue-based reference model checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_lib_voq_input_buffer;

  localparam int unsigned M     = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             ce;
  logic [WIDTH-1:0] i_data;
  logic [1:0]       i_dest;
  logic             i_valid;
  logic [0:M-1]     o_full;
  logic             o_overflow;
  logic [0:M-1]     o_request;
  logic [0:M-1]     i_grant;
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic [0:M-1]     o_dest;
  logic             o_error;

  lib_voq_input_buffer #(.M(M), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .ce(ce), .i_data(i_data), .i_dest(i_dest),
    .i_valid(i_valid), .o_full(o_full), .o_overflow(o_overflow),
    .o_request(o_request), .i_grant(i_grant), .o_data(o_data),
    .o_valid(o_valid), .o_dest(o_dest), .o_error(o_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: one queue per output, evaluated at each rising edge.
  logic [WIDTH-1:0] mq [M][$];
  logic             m_valid, m_ovf, m_err;
  logic [WIDTH-1:0] m_data;
  logic [0:M-1]     m_dest;
  logic             started = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < M; j++) mq[j].delete();
      m_valid = 1'b0; m_ovf = 1'b0; m_err = 1'b0;
      m_data = '0; m_dest = '0;
      started = 1'b1;
    end else begin
      int g;
      bit push_full;
      m_valid = 1'b0; m_ovf = 1'b0; m_err = 1'b0;
      if (ce) begin
        push_full = (mq[i_dest].size() == DEPTH);
        g = -1;
        for (int j = M - 1; j >= 0; j--) if (i_grant[j]) g = j;
        if (g >= 0) begin
          if (mq[g].size() == 0) begin
            m_err = 1'b1;
          end else begin
            m_valid = 1'b1;
            m_data  = mq[g].pop_front();
            m_dest  = '0;
            m_dest[g] = 1'b1;
            if ($countones(i_grant) > 1) m_err = 1'b1;
          end
        end
        if (i_valid) begin
          if (push_full) m_ovf = 1'b1;
          else mq[i_dest].push_back(i_data);
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      logic [0:M-1] e_req, e_full;
      for (int j = 0; j < M; j++) begin
        e_req[j]  = (mq[j].size() != 0);
        e_full[j] = (mq[j].size() == DEPTH);
      end
      chk("request", 64'(o_request), 64'(e_req));
      chk("full", 64'(o_full), 64'(e_full));
      chk("valid", 64'(o_valid), 64'(m_valid));
      chk("data", 64'(o_data), 64'(m_data));
      chk("dest", 64'(o_dest), 64'(m_dest));
      chk("overflow", 64'(o_overflow), 64'(m_ovf));
      chk("error", 64'(o_error), 64'(m_err));
    end
  end

  // Apply one cycle of inputs, then return 1ns after the consuming edge.
  task automatic step(input logic v, input logic [1:0] d, input logic [WIDTH-1:0] x,
                      input logic [0:M-1] g, input logic c);
    i_valid = v; i_dest = d; i_data = x; i_grant = g; ce = c;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1'b0, 2'd0, '0, 4'b0000, 1'b1);
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; i_valid = 1'b0; i_dest = '0; i_data = '0; i_grant = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("lit_reset_request", 64'(o_request), 64'h0);
    chk("lit_reset_valid", 64'(o_valid), 64'h0);

    // 1: three flits to VOQ 2
    step(1'b1, 2'd2, 32'hA0, 4'b0000, 1'b1);
    chk("lit_t1_request", 64'(o_request), 64'b0010);
    step(1'b1, 2'd2, 32'hA1, 4'b0000, 1'b1);
    step(1'b1, 2'd2, 32'hA2, 4'b0000, 1'b1);
    chk("lit_t1_full", 64'(o_full), 64'h0);
    chk("lit_t1_valid", 64'(o_valid), 64'h0);

    // 2: drain VOQ 2 in order
    step(1'b0, 2'd0, '0, 4'b0010, 1'b1);
    chk("lit_t2_data0", 64'(o_data), 64'hA0);
    chk("lit_t2_dest0", 64'(o_dest), 64'b0010);
    step(1'b0, 2'd0, '0, 4'b0010, 1'b1);
    chk("lit_t2_data1", 64'(o_data), 64'hA1);
    step(1'b0, 2'd0, '0, 4'b0010, 1'b1);
    chk("lit_t2_data2", 64'(o_data), 64'hA2);
    chk("lit_t2_request", 64'(o_request), 64'h0);
    chk("lit_t2_error", 64'(o_error), 64'h0);
    idle();
    chk("lit_t2_idle_valid", 64'(o_valid), 64'h0);

    // 3: fill VOQ 1, reject push while popping the same VOQ
    for (int k = 0; k < 4; k++) step(1'b1, 2'd1, 32'hB0 + 32'(k), 4'b0000, 1'b1);
    chk("lit_t3_full", 64'(o_full), 64'b0100);
    step(1'b1, 2'd1, 32'hB4, 4'b0100, 1'b1);
    chk("lit_t3_overflow", 64'(o_overflow), 64'h1);
    chk("lit_t3_pop_b0", 64'(o_data), 64'hB0);
    for (int k = 1; k < 4; k++) begin
      step(1'b0, 2'd0, '0, 4'b0100, 1'b1);
      chk("lit_t3_drain", 64'(o_data), 64'hB0 + 64'(k));
      chk("lit_t3_ovf_clear", 64'(o_overflow), 64'h0);
    end
    chk("lit_t3_request", 64'(o_request), 64'h0);

    // 4: wrap VOQ 3 pointers, then simultaneous push/pop
    for (int k = 0; k < 3; k++) step(1'b1, 2'd3, 32'hD0 + 32'(k), 4'b0000, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 2'd0, '0, 4'b0001, 1'b1);
    step(1'b1, 2'd3, 32'hC0, 4'b0000, 1'b1);
    step(1'b1, 2'd3, 32'hC1, 4'b0000, 1'b1);
    step(1'b1, 2'd3, 32'hC2, 4'b0001, 1'b1);
    chk("lit_t4_pop_c0", 64'(o_data), 64'hC0);
    step(1'b0, 2'd0, '0, 4'b0001, 1'b1);
    chk("lit_t4_pop_c1", 64'(o_data), 64'hC1);
    step(1'b0, 2'd0, '0, 4'b0001, 1'b1);
    chk("lit_t4_pop_c2", 64'(o_data), 64'hC2);
    chk("lit_t4_request", 64'(o_request), 64'h0);

    // 5: grant to empty VOQ, then a double grant
    step(1'b0, 2'd0, '0, 4'b1000, 1'b1);
    chk("lit_t5_err_empty", 64'(o_error), 64'h1);
    chk("lit_t5_valid_empty", 64'(o_valid), 64'h0);
    step(1'b1, 2'd1, 32'hE1, 4'b0000, 1'b1);
    chk("lit_t5_err_clear", 64'(o_error), 64'h0);
    step(1'b1, 2'd2, 32'hE2, 4'b0000, 1'b1);
    step(1'b0, 2'd0, '0, 4'b0110, 1'b1);
    chk("lit_t5_multi_err", 64'(o_error), 64'h1);
    chk("lit_t5_multi_data", 64'(o_data), 64'hE1);
    chk("lit_t5_multi_dest", 64'(o_dest), 64'b0100);
    chk("lit_t5_multi_req", 64'(o_request), 64'b0010);
    step(1'b0, 2'd0, '0, 4'b0010, 1'b1);
    chk("lit_t5_pop_e2", 64'(o_data), 64'hE2);

    // 6: clock enable low, then reset mid-operation
    step(1'b1, 2'd1, 32'hF1, 4'b0000, 1'b1);
    step(1'b1, 2'd2, 32'hF2, 4'b0000, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 2'd2, 32'hF9, 4'b0100, 1'b0);
      chk("lit_t6_ce_valid", 64'(o_valid), 64'h0);
      chk("lit_t6_ce_req", 64'(o_request), 64'b0110);
    end
    reset = 1'b1;
    step(1'b0, 2'd0, '0, 4'b0000, 1'b1);
    reset = 1'b0;
    chk("lit_t6_rst_req", 64'(o_request), 64'h0);
    chk("lit_t6_rst_full", 64'(o_full), 64'h0);
    chk("lit_t6_rst_valid", 64'(o_valid), 64'h0);
    step(1'b0, 2'd0, '0, 4'b0100, 1'b1);
    chk("lit_t6_post_err", 64'(o_error), 64'h1);
    idle();
    idle();

    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
